serial_link_credit_ctrl: RTL and testbench

Credit-based flow controller between the serial link network layer (packet producer/consumer) and the data link layer (AXIS toward the PHY).
- Tracks how many packets the remote receive buffer can still take, and stalls the local sender when no credits remain.
- Counts packets the local consumer has drained and returns these credits to the remote side. Credits ride on outgoing data packets, or on a credit-only packet when no data is pending.

---
 rtl/serial_link_pkg.sv | 18 +
 rtl/serial_link_credit_cnt.sv | 43 ++++
 rtl/serial_link_credit_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_link_credit_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared types and constants for the serial link credit flow control
package serial_link_pkg;

    localparam int unsigned DefaultNumCredits = 8;
    localparam int unsigned CreditW           = $clog2(DefaultNumCredits + 1);

    typedef logic [CreditW-1:0] credit_t;

    // Header tag the data link layer stamps on credit-only frames.
    localparam logic [7:0] TagCredit = 8'hC3;

    typedef enum logic [1:0] {
        TxEmpty      = 2'd0,
        TxData       = 2'd1,
        TxCreditOnly = 2'd2
    } tx_state_e;

endpackage

// File: rtl/serial_link_credit_cnt.sv
// rtl/serial_link_credit_cnt.sv - saturating credit counter with add-N / subtract-1 / clear in one cycle
module serial_link_credit_cnt #(
    parameter int unsigned MaxVal  = 8,
    parameter int unsigned InitVal = 0,
    parameter int unsigned CntW    = $clog2(MaxVal + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_en_i,
    input  logic [CntW-1:0] inc_amt_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            overflow_o
);

    localparam int unsigned    SumW   = CntW + 1;
    localparam logic [SumW-1:0] MaxSum = SumW'(MaxVal);

    logic [CntW-1:0] r_count;
    logic [SumW-1:0] w_base;
    logic [SumW-1:0] w_sum;
    logic [CntW-1:0] w_next;

    // One extra bit of headroom lets overflow and underflow both show up as "above MaxVal".
    always_comb begin
        w_base     = clr_i ? '0 : {1'b0, r_count};
        w_sum      = w_base + (inc_en_i ? {1'b0, inc_amt_i} : '0) - {{CntW{1'b0}}, dec_i};
        overflow_o = (w_sum > MaxSum);
        w_next     = overflow_o ? CntW'(MaxVal) : w_sum[CntW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= CntW'(InitVal);
        end else begin
            r_count <= w_next;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/serial_link_credit_ctrl.sv
// rtl/serial_link_credit_ctrl.sv - credit-based flow control between network layer and data link layer
module serial_link_credit_ctrl
    import serial_link_pkg::*;
#(
    parameter int unsigned NumCredits        = 8,
    parameter int unsigned ForceCreditThresh = 6,
    parameter int unsigned IdleTimeout       = 16,
    parameter type         payload_t         = logic,
    parameter int unsigned CntW              = $clog2(NumCredits + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  payload_t        req_data_i,
    output logic            tx_valid_o,
    input  logic            tx_ready_i,
    output payload_t        tx_data_o,
    output logic            tx_credit_only_o,
    output logic [CntW-1:0] tx_credits_o,
    input  logic            rx_valid_i,
    input  logic [CntW-1:0] rx_credits_i,
    input  logic            rx_consumed_i,
    output logic [CntW-1:0] credits_avail_o,
    output logic [CntW-1:0] credits_pending_o
);

    localparam int unsigned     IdleW     = (IdleTimeout > 1) ? $clog2(IdleTimeout) : 1;
    localparam logic [IdleW-1:0] IdleMax   = IdleW'(IdleTimeout - 1);
    localparam logic [CntW-1:0]  ThreshVal = CntW'(ForceCreditThresh);

    tx_state_e        r_state;
    tx_state_e        w_state_next;
    payload_t         r_tx_data;
    logic [CntW-1:0]  r_tx_credits;
    logic [IdleW-1:0] r_idle;

    logic [CntW-1:0]  w_avail;
    logic [CntW-1:0]  w_pending;
    logic             w_avail_ovf;
    logic             w_pending_ovf;
    logic             w_tx_hs;
    logic             w_free;
    logic             w_req_hs;
    logic             w_credit_load;
    logic             w_load;

    serial_link_credit_cnt #(
        .MaxVal  (NumCredits),
        .InitVal (NumCredits),
        .CntW    (CntW)
    ) u_avail_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (1'b0),
        .inc_en_i   (rx_valid_i),
        .inc_amt_i  (rx_credits_i),
        .dec_i      (w_req_hs),
        .count_o    (w_avail),
        .overflow_o (w_avail_ovf)
    );

    // Clearing on load while adding the same-cycle consume keeps that consume for the next packet.
    serial_link_credit_cnt #(
        .MaxVal  (NumCredits),
        .InitVal (0),
        .CntW    (CntW)
    ) u_pending_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (w_load),
        .inc_en_i   (rx_consumed_i),
        .inc_amt_i  (CntW'(1)),
        .dec_i      (1'b0),
        .count_o    (w_pending),
        .overflow_o (w_pending_ovf)
    );

    always_comb begin
        w_tx_hs       = (r_state != TxEmpty) && tx_ready_i;
        w_free        = (r_state == TxEmpty) || w_tx_hs;
        req_ready_o   = rst_ni && w_free && (w_avail != '0);
        w_req_hs      = req_valid_i && req_ready_o;
        // An empty send window forces credits out so both sides cannot starve each other.
        w_credit_load = w_free && !w_req_hs && (w_pending != '0) &&
                        ((w_pending >= ThreshVal) || (r_idle == IdleMax) || (w_avail == '0));
        w_load        = w_req_hs || w_credit_load;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= TxEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_req_hs) begin
            w_state_next = TxData;
        end else if (w_credit_load) begin
            w_state_next = TxCreditOnly;
        end else if (w_tx_hs) begin
            w_state_next = TxEmpty;
        end
    end

    always_comb begin
        tx_valid_o        = (r_state != TxEmpty);
        tx_credit_only_o  = (r_state == TxCreditOnly);
        tx_data_o         = r_tx_data;
        tx_credits_o      = r_tx_credits;
        credits_avail_o   = w_avail;
        credits_pending_o = w_pending;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_data    <= '0;
            r_tx_credits <= '0;
        end else if (w_req_hs) begin
            r_tx_data    <= req_data_i;
            r_tx_credits <= w_pending;
        end else if (w_credit_load) begin
            r_tx_data    <= '0;
            r_tx_credits <= w_pending;
        end else if (w_tx_hs) begin
            r_tx_credits <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idle <= '0;
        end else if (w_load || (w_pending == '0)) begin
            r_idle <= '0;
        end else if (r_idle != IdleMax) begin
            r_idle <= r_idle + IdleW'(1);
        end
    end

    a_tx_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (tx_valid_o && !tx_ready_i) |=> (tx_valid_o && $stable(tx_data_o) &&
                                         $stable(tx_credits_o) && $stable(tx_credit_only_o)));

    a_no_send_without_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_req_hs && (w_avail == '0)));

    a_avail_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_avail_ovf);

    a_pending_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_pending_ovf);

endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
// tb/tb_serial_link_credit_ctrl.sv - directed self-checking bench for serial_link_credit_ctrl
module tb_serial_link_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready_o;
    logic [7:0] req_data = 8'h00;
    logic       tx_valid_o;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data_o;
    logic       tx_credit_only_o;
    logic [2:0] tx_credits_o;
    logic       rx_valid = 1'b0;
    logic [2:0] rx_credits = 3'd0;
    logic       rx_consumed = 1'b0;
    logic [2:0] credits_avail_o;
    logic [2:0] credits_pending_o;

    int n_checks = 0;
    int n_errors = 0;

    serial_link_credit_ctrl #(
        .NumCredits        (4),
        .ForceCreditThresh (3),
        .IdleTimeout       (8),
        .payload_t         (logic [7:0])
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready_o),
        .req_data_i        (req_data),
        .tx_valid_o        (tx_valid_o),
        .tx_ready_i        (tx_ready),
        .tx_data_o         (tx_data_o),
        .tx_credit_only_o  (tx_credit_only_o),
        .tx_credits_o      (tx_credits_o),
        .rx_valid_i        (rx_valid),
        .rx_credits_i      (rx_credits),
        .rx_consumed_i     (rx_consumed),
        .credits_avail_o   (credits_avail_o),
        .credits_pending_o (credits_pending_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid   = 1'b0;
        req_data    = 8'h00;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        rx_credits  = 3'd0;
        rx_consumed = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (tx_valid_o !== 1'b0 || tx_credit_only_o !== 1'b0 || tx_data_o !== 8'h00 || tx_credits_o !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_tx: valid=%b co=%b data=%h cr=%0d, required all zero",
                     tx_valid_o, tx_credit_only_o, tx_data_o, tx_credits_o);
        end
        n_checks++;
        if (req_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready: got %b required 0", req_ready_o);
        end
        n_checks++;
        if (credits_avail_o !== 3'd4 || credits_pending_o !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_counters: avail=%0d pending=%0d required 4/0", credits_avail_o, credits_pending_o);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_reset: got %b required 1", req_ready_o);
        end
        tick();
    endtask

    task automatic test_exhaustion();
        int acc;
        do_reset();
        tx_ready  = 1'b1;
        req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_data = 8'h10 + 8'(i);
            #1;
            if (i == 4) begin
                n_checks++;
                if (req_ready_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL exhaust_ready_c5: got %b required 0", req_ready_o);
                end
            end
            if (req_ready_o === 1'b1) acc++;
            tick();
            if (i == 0) begin
                n_checks++;
                if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h10 || tx_credit_only_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL exhaust_first_pkt: valid=%b data=%h co=%b required 1/10/0",
                             tx_valid_o, tx_data_o, tx_credit_only_o);
                end
            end
        end
        n_checks++;
        if (acc != 4) begin
            n_errors++;
            $display("FAIL exhaust_accepted: got %0d required 4", acc);
        end
        n_checks++;
        if (credits_avail_o !== 3'd0) begin
            n_errors++;
            $display("FAIL exhaust_avail: got %0d required 0", credits_avail_o);
        end
        rx_valid   = 1'b1;
        rx_credits = 3'd2;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL exhaust_ready_rx_cycle: got %b required 0", req_ready_o);
        end
        tick();
        rx_valid   = 1'b0;
        rx_credits = 3'd0;
        n_checks++;
        if (credits_avail_o !== 3'd2) begin
            n_errors++;
            $display("FAIL exhaust_avail_refill: got %0d required 2", credits_avail_o);
        end
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (req_ready_o === 1'b1) acc++;
            tick();
        end
        n_checks++;
        if (acc != 2 || credits_avail_o !== 3'd0) begin
            n_errors++;
            $display("FAIL exhaust_refill_accepted: got %0d avail=%0d required 2 avail=0", acc, credits_avail_o);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_piggyback();
        do_reset();
        tx_ready    = 1'b1;
        rx_consumed = 1'b1;
        tick();
        tick();
        rx_consumed = 1'b0;
        req_valid   = 1'b1;
        req_data    = 8'hAA;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (tx_valid_o !== 1'b1 || tx_credits_o !== 3'd2 || tx_credit_only_o !== 1'b0 || tx_data_o !== 8'hAA) begin
            n_errors++;
            $display("FAIL piggy_pkt: valid=%b cr=%0d co=%b data=%h required 1/2/0/AA",
                     tx_valid_o, tx_credits_o, tx_credit_only_o, tx_data_o);
        end
        n_checks++;
        if (credits_pending_o !== 3'd0) begin
            n_errors++;
            $display("FAIL piggy_pending_cleared: got %0d required 0", credits_pending_o);
        end
        rx_consumed = 1'b1;
        tick();
        tick();
        req_valid = 1'b1;
        req_data  = 8'hBB;
        tick();
        req_valid   = 1'b0;
        rx_consumed = 1'b0;
        n_checks++;
        if (tx_credits_o !== 3'd2 || credits_pending_o !== 3'd1) begin
            n_errors++;
            $display("FAIL piggy_consume_on_load: cr=%0d pending=%0d required 2/1", tx_credits_o, credits_pending_o);
        end
    endtask

    task automatic test_threshold();
        do_reset();
        tx_ready    = 1'b1;
        rx_consumed = 1'b1;
        tick();
        tick();
        tick();
        rx_consumed = 1'b0;
        n_checks++;
        if (credits_pending_o !== 3'd3 || tx_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL thresh_before: pending=%0d valid=%b required 3/0", credits_pending_o, tx_valid_o);
        end
        tick();
        n_checks++;
        if (tx_valid_o !== 1'b1 || tx_credit_only_o !== 1'b1 || tx_credits_o !== 3'd3 || tx_data_o !== 8'h00) begin
            n_errors++;
            $display("FAIL thresh_pkt: valid=%b co=%b cr=%0d data=%h required 1/1/3/00",
                     tx_valid_o, tx_credit_only_o, tx_credits_o, tx_data_o);
        end
        n_checks++;
        if (credits_avail_o !== 3'd4 || credits_pending_o !== 3'd0) begin
            n_errors++;
            $display("FAIL thresh_counters: avail=%0d pending=%0d required 4/0", credits_avail_o, credits_pending_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        do_reset();
        tx_ready    = 1'b0;
        rx_consumed = 1'b1;
        tick();
        rx_consumed = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            if (tx_valid_o === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || n != 8) begin
            n_errors++;
            $display("FAIL timeout_latency: seen=%b cycles=%0d required 8", seen, n);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (tx_valid_o !== 1'b1 || tx_credit_only_o !== 1'b1 || tx_credits_o !== 3'd1 || tx_data_o !== 8'h00) begin
                n_errors++;
                $display("FAIL timeout_stall_%0d: valid=%b co=%b cr=%0d data=%h required 1/1/1/00",
                         i, tx_valid_o, tx_credit_only_o, tx_credits_o, tx_data_o);
            end
        end
        tx_ready = 1'b1;
        tick();
        n_checks++;
        if (tx_valid_o !== 1'b0 || tx_credit_only_o !== 1'b0 || tx_credits_o !== 3'd0) begin
            n_errors++;
            $display("FAIL timeout_drain: valid=%b co=%b cr=%0d required 0/0/0",
                     tx_valid_o, tx_credit_only_o, tx_credits_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tx_ready  = 1'b1;
        req_valid = 1'b1;
        tick();
        tick();
        tick();
        req_valid   = 1'b0;
        rx_consumed = 1'b1;
        tick();
        tick();
        req_valid  = 1'b1;
        req_data   = 8'h55;
        rx_valid   = 1'b1;
        rx_credits = 3'd3;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1 || credits_avail_o !== 3'd1 || credits_pending_o !== 3'd2) begin
            n_errors++;
            $display("FAIL simul_pre: ready=%b avail=%0d pending=%0d required 1/1/2",
                     req_ready_o, credits_avail_o, credits_pending_o);
        end
        tick();
        clear_inputs();
        tx_ready = 1'b1;
        n_checks++;
        if (credits_avail_o !== 3'd3 || credits_pending_o !== 3'd1) begin
            n_errors++;
            $display("FAIL simul_counters: avail=%0d pending=%0d required 3/1", credits_avail_o, credits_pending_o);
        end
        n_checks++;
        if (tx_credits_o !== 3'd2 || tx_data_o !== 8'h55 || tx_credit_only_o !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_pkt: cr=%0d data=%h co=%b required 2/55/0", tx_credits_o, tx_data_o, tx_credit_only_o);
        end
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        tx_ready  = 1'b1;
        req_valid = 1'b1;
        tick();
        tick();
        tick();
        req_valid = 1'b0;
        tx_ready  = 1'b0;
        n_checks++;
        if (tx_valid_o !== 1'b1 || credits_avail_o !== 3'd1) begin
            n_errors++;
            $display("FAIL midrst_pre: valid=%b avail=%0d required 1/1", tx_valid_o, credits_avail_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: valid=%b ready=%b required 0/0", tx_valid_o, req_ready_o);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (credits_avail_o !== 3'd4 || credits_pending_o !== 3'd0 || req_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_after: avail=%0d pending=%0d ready=%b required 4/0/1",
                     credits_avail_o, credits_pending_o, req_ready_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_exhaustion();
        test_piggyback();
        test_threshold();
        test_timeout();
        test_simultaneous();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
